// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: measures the period of a divided clock and recovers its division value and code
// Ports:
//    clk       system clock, all state on its rising edge
//    rst       asynchronous active-low reset
//    senal     divided clock under measurement, asynchronous to clk
//    periodo   last measured period in clk cycles
//    q         periodo>>1 saturated at 127
//    codigo    table entry matching the last period
//    valido    one-cycle pulse when periodo/q/codigo/error update
//    error     last period matched no table entry (or saturated)
//    sin_senal no rising edge for TIMEOUT cycles
module medidor_frecuencia #(
   parameter int ANCHO   = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             senal,
   output logic [ANCHO-1:0] periodo,
   output logic [6:0]       q,
   output logic [2:0]       codigo,
   output logic             valido,
   output logic             error,
   output logic             sin_senal
);
   localparam int AO = $clog2(TIMEOUT + 1);
   localparam int DIV [8] = '{2, 4, 8, 16, 32, 50, 100, 125};
   typedef enum logic [1:0] {ESPERA, PRIMER, MIDIENDO} estado_t;
   estado_t estado, estado_sig;
   logic s0, s1, s2;
   logic [ANCHO-1:0] cnt;
   logic [AO-1:0] ocio;
   logic flanco, expira, medir, sat, hit;
   logic [2:0] sel;
   logic [6:0] q_n;
   assign flanco = s1 & ~s2;
   // an edge in the expiry cycle wins, so expiry requires no edge
   assign expira = (estado != ESPERA) && !flanco && (ocio == AO'(TIMEOUT - 1));
   // the first edge after ESPERA only starts the count; later edges close a period
   assign medir  = flanco && (estado != ESPERA);
   assign sat    = &cnt;
   assign q_n    = (cnt[ANCHO-1:1] > 127) ? 7'd127 : cnt[7:1];
   always_comb begin
      estado_sig = flanco ? ((estado == ESPERA) ? PRIMER : MIDIENDO) : (expira ? ESPERA : estado);
   end
   always_comb begin
      hit = 1'b0;
      sel = codigo;
      for (int i = 0; i < 8; i++)
         if (int'(cnt) >= 2 * DIV[i] - 1 && int'(cnt) <= 2 * DIV[i] + 1) begin
            hit = 1'b1;
            sel = 3'(i);
         end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado    <= ESPERA;
         s0        <= 1'b0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         cnt       <= '0;
         ocio      <= '0;
         periodo   <= '0;
         q         <= '0;
         codigo    <= '0;
         valido    <= 1'b0;
         error     <= 1'b0;
         sin_senal <= 1'b0;
      end else begin
         s0        <= senal;
         s1        <= s0;
         s2        <= s1;
         estado    <= estado_sig;
         cnt       <= flanco ? ANCHO'(1) : (estado == ESPERA) ? '0 : sat ? cnt : cnt + 1'b1;
         ocio      <= (flanco || expira || estado == ESPERA) ? '0 : ocio + 1'b1;
         valido    <= medir;
         sin_senal <= medir ? 1'b0 : expira ? 1'b1 : sin_senal;
         if (medir) begin
            periodo <= cnt;
            q       <= q_n;
            codigo  <= sel;
            error   <= sat | ~hit;
         end
      end
   end
endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb_medidor_frecuencia: randomized and directed checks of medidor_frecuencia against a period-level model
module tb_medidor_frecuencia;
   logic clk = 0, rst = 0, senal_a = 0, senal_b = 0;
   logic [15:0] periodo_a;
   logic [7:0]  periodo_b;
   logic [6:0]  q_a, q_b;
   logic [2:0]  codigo_a, codigo_b;
   logic valido_a, valido_b, error_a, error_b, sin_a, sin_b;
   int checks = 0, errors = 0;
   int ep, eq, ee, cod_m, k;
   int plan[$];
   typedef struct {int per; int q; int cod; int err; int sin;} obs_t;
   obs_t obs_a[$], obs_b[$];

   always #5 clk = ~clk;

   medidor_frecuencia dut_a (.clk(clk), .rst(rst), .senal(senal_a), .periodo(periodo_a), .q(q_a),
      .codigo(codigo_a), .valido(valido_a), .error(error_a), .sin_senal(sin_a));
   medidor_frecuencia #(.ANCHO(8), .TIMEOUT(300)) dut_b (.clk(clk), .rst(rst), .senal(senal_b),
      .periodo(periodo_b), .q(q_b), .codigo(codigo_b), .valido(valido_b), .error(error_b), .sin_senal(sin_b));

   always @(negedge clk) begin
      obs_t o;
      if (valido_a) begin
         o.per = int'(periodo_a); o.q = int'(q_a); o.cod = int'(codigo_a); o.err = int'(error_a); o.sin = int'(sin_a);
         obs_a.push_back(o);
      end
      if (valido_b) begin
         o.per = int'(periodo_b); o.q = int'(q_b); o.cod = int'(codigo_b); o.err = int'(error_b); o.sin = int'(sin_b);
         obs_b.push_back(o);
      end
   end

   // expected report for one complete period of p cycles on a counter that tops out at maxv
   function automatic void modelo(input int p, input int maxv, inout int cod, output int per, output int qq, output int err);
      int div[8] = '{2, 4, 8, 16, 32, 50, 100, 125};
      int hit = 0;
      per = (p > maxv) ? maxv : p;
      qq  = (per / 2 > 127) ? 127 : per / 2;
      for (int i = 0; i < 8; i++)
         if (per >= 2 * div[i] - 1 && per <= 2 * div[i] + 1) begin hit = 1; cod = i; end
      err = (hit == 0 || per == maxv) ? 1 : 0;
   endfunction

   task automatic poner(input bit b, input logic v);
      if (b) senal_b = v; else senal_a = v;
   endtask

   // one rising edge per plan entry, then a closing edge so every planned period is reported
   task automatic correr(input bit b, input int h);
      foreach (plan[i]) begin
         poner(b, 1); repeat (h) @(negedge clk);
         poner(b, 0); repeat (plan[i] - h) @(negedge clk);
      end
      poner(b, 1); repeat (h) @(negedge clk);
      poner(b, 0); repeat (8) @(negedge clk);
   endtask

   task automatic reiniciar;
      @(negedge clk);
      rst = 0; senal_a = 0; senal_b = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      obs_a.delete(); obs_b.delete(); cod_m = 0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (periodo_a !== 0) begin errors++; $display("FAIL reset periodo got=%0d exp=0", periodo_a); end
      checks++; if (q_a !== 0) begin errors++; $display("FAIL reset q got=%0d exp=0", q_a); end
      checks++; if (codigo_a !== 0) begin errors++; $display("FAIL reset codigo got=%0d exp=0", codigo_a); end
      checks++; if (valido_a !== 0) begin errors++; $display("FAIL reset valido got=%0d exp=0", valido_a); end
      checks++; if (error_a !== 0) begin errors++; $display("FAIL reset error got=%0d exp=0", error_a); end
      checks++; if (sin_a !== 0) begin errors++; $display("FAIL reset sin_senal got=%0d exp=0", sin_a); end
      rst = 1;
      @(negedge clk);
   endtask

   task automatic test_lista_a(input string nm, input int h);
      correr(0, h);
      checks++;
      if (obs_a.size() != plan.size()) begin errors++; $display("FAIL %s valido_count got=%0d exp=%0d", nm, obs_a.size(), plan.size()); end
      foreach (plan[i]) begin
         modelo(plan[i], 65535, cod_m, ep, eq, ee);
         checks++;
         if (i >= obs_a.size() || obs_a[i].per != ep || obs_a[i].q != eq || obs_a[i].cod != cod_m || obs_a[i].err != ee || obs_a[i].sin != 0) begin
            errors++;
            $display("FAIL %s[%0d] got per=%0d q=%0d cod=%0d err=%0d sin=%0d exp per=%0d q=%0d cod=%0d err=%0d sin=0",
               nm, i, obs_a[i].per, obs_a[i].q, obs_a[i].cod, obs_a[i].err, obs_a[i].sin, ep, eq, cod_m, ee);
         end
      end
   endtask

   task automatic test_periodo16;
      reiniciar; plan = '{16, 16, 16};
      test_lista_a("periodo16", 8);
   endtask

   task automatic test_tabla;
      reiniciar; plan = '{200, 201, 199, 70, 200};
      test_lista_a("tabla", 5);
   endtask

   task automatic test_aleatorio;
      int div[8] = '{2, 4, 8, 16, 32, 50, 100, 125};
      reiniciar; plan.delete();
      for (int i = 0; i < 20; i++)
         plan.push_back($urandom_range(0, 1) ? 2 * div[$urandom_range(2, 7)] + int'($urandom_range(0, 2)) - 1 : int'($urandom_range(6, 400)));
      test_lista_a("aleatorio", 3);
   endtask

   task automatic test_timeout;
      reiniciar;
      poner(0, 1); repeat (2) @(negedge clk); poner(0, 0); repeat (2) @(negedge clk);
      poner(0, 1);
      k = 0;
      while (sin_a !== 1 && k < 70000) begin
         @(negedge clk); k++;
         if (k == 2) poner(0, 0);
      end
      checks++; if (k != 65538) begin errors++; $display("FAIL timeout latency got=%0d exp=65538", k); end
      checks++;
      if (obs_a.size() != 1 || obs_a[0].per != 4 || obs_a[0].cod != 0 || obs_a[0].err != 0) begin
         errors++; $display("FAIL timeout report got n=%0d per=%0d cod=%0d err=%0d exp n=1 per=4 cod=0 err=0", obs_a.size(), obs_a[0].per, obs_a[0].cod, obs_a[0].err);
      end
      checks++; if (periodo_a !== 4 || q_a !== 2) begin errors++; $display("FAIL timeout hold got per=%0d q=%0d exp per=4 q=2", periodo_a, q_a); end
      obs_a.delete();
      poner(0, 1); repeat (8) @(negedge clk); poner(0, 0); repeat (8) @(negedge clk);
      checks++;
      if (obs_a.size() != 0 || sin_a !== 1) begin errors++; $display("FAIL restart_first got n=%0d sin=%0d exp n=0 sin=1", obs_a.size(), sin_a); end
      poner(0, 1); repeat (8) @(negedge clk); poner(0, 0); repeat (4) @(negedge clk);
      checks++;
      if (obs_a.size() != 1 || obs_a[0].per != 16 || obs_a[0].cod != 2 || obs_a[0].err != 0 || obs_a[0].sin != 0 || sin_a !== 0) begin
         errors++; $display("FAIL restart_second got n=%0d per=%0d cod=%0d sin=%0d exp n=1 per=16 cod=2 sin=0", obs_a.size(), obs_a[0].per, obs_a[0].cod, sin_a);
      end
   endtask

   task automatic test_reset_async;
      reiniciar; plan = '{64, 64};
      correr(0, 8);
      checks++; if (periodo_a !== 64) begin errors++; $display("FAIL prereset periodo got=%0d exp=64", periodo_a); end
      poner(0, 1); repeat (8) @(negedge clk); poner(0, 0); repeat (2) @(negedge clk);
      #2 rst = 0;
      #1;
      checks++;
      if ({periodo_a, q_a, codigo_a, valido_a, error_a, sin_a} !== '0) begin
         errors++; $display("FAIL async_reset got per=%0d q=%0d cod=%0d v=%0d err=%0d sin=%0d exp all 0", periodo_a, q_a, codigo_a, valido_a, error_a, sin_a);
      end
      repeat (3) @(negedge clk);
      rst = 1; obs_a.delete(); cod_m = 0;
      test_lista_a("post_reset64", 8);
   endtask

   task automatic test_saturacion_b(input string nm, input int p);
      reiniciar; plan = '{p};
      correr(1, 4);
      modelo(p, 255, cod_m, ep, eq, ee);
      checks++;
      if (obs_b.size() != 1 || obs_b[0].per != ep || obs_b[0].q != eq || obs_b[0].cod != cod_m || obs_b[0].err != ee || obs_b[0].sin != 0 || sin_b !== 0) begin
         errors++;
         $display("FAIL %s got n=%0d per=%0d q=%0d cod=%0d err=%0d sin=%0d exp n=1 per=%0d q=%0d cod=%0d err=%0d sin=0",
            nm, obs_b.size(), obs_b[0].per, obs_b[0].q, obs_b[0].cod, obs_b[0].err, sin_b, ep, eq, cod_m, ee);
      end
   endtask

   task automatic test_pasado_b;
      reiniciar; plan = '{301};
      correr(1, 4);
      checks++;
      if (obs_b.size() != 0 || sin_b !== 1) begin errors++; $display("FAIL past_timeout got n=%0d sin=%0d exp n=0 sin=1", obs_b.size(), sin_b); end
   endtask

   initial begin
      test_reset;
      test_periodo16;
      test_tabla;
      test_aleatorio;
      test_reset_async;
      test_saturacion_b("saturacion", 280);
      test_saturacion_b("coincidente", 300);
      test_saturacion_b("cod125", 250);
      test_pasado_b;
      test_timeout;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
